irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 115 +++++++++++
 tb/tb_irq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Four-source fixed-priority interrupt controller with a CPU I/O register window at 24h..27h.
// One request is outstanding at a time: request, acknowledge, then end-of-interrupt.
module irq_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [7:0]  o,
  input  logic        r,
  input  logic        w,
  input  logic        ev_vblank,
  input  logic        ev_kdone,
  input  logic        ev_timer,
  input  logic        irq_ack,
  output logic        irq,
  output logic [1:0]  irq_vec,
  output logic [7:0]  p
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_t;

  localparam logic [15:0] ADDR_MASK = 16'h0024;
  localparam logic [15:0] ADDR_PEND = 16'h0025;
  localparam logic [15:0] ADDR_STAT = 16'h0026;
  localparam logic [15:0] ADDR_SWI  = 16'h0027;

  state_t     state, state_next;
  logic [1:0] vec_next;
  logic       ge;
  logic [3:0] en;
  logic [3:0] pend, pend_next;
  logic [3:0] cand, set_bits, w1c_bits, ack_bits;
  logic       wr_mask, wr_pend, wr_stat, wr_swi;

  // Reads are side-effect free, so the read strobe carries no information here.
  logic unused_read_strobe;
  assign unused_read_strobe = r;

  assign wr_mask = w && (a == ADDR_MASK);
  assign wr_pend = w && (a == ADDR_PEND);
  assign wr_stat = w && (a == ADDR_STAT);
  assign wr_swi  = w && (a == ADDR_SWI);

  assign cand     = pend & en;
  assign set_bits = {wr_swi && o[0], ev_timer, ev_kdone, ev_vblank};
  assign w1c_bits = wr_pend ? o[3:0] : 4'b0000;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    vec_next   = irq_vec;
    ack_bits   = 4'b0000;
    unique case (state)
      ST_IDLE: begin
        if (ge && (cand != 4'b0000)) begin
          state_next = ST_REQ;
          if (cand[0])      vec_next = 2'd0;
          else if (cand[1]) vec_next = 2'd1;
          else if (cand[2]) vec_next = 2'd2;
          else              vec_next = 2'd3;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_next        = ST_SERVICE;
          ack_bits[irq_vec] = 1'b1;
        end else if (!ge) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_stat) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sets are ORed in last so an event beats a same-cycle W1C or acknowledge clear.
  assign pend_next = (pend & ~w1c_bits & ~ack_bits) | set_bits;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      irq     <= 1'b0;
      irq_vec <= 2'd0;
      pend    <= 4'b0000;
      ge      <= 1'b0;
      en      <= 4'b0000;
    end else begin
      state   <= state_next;
      irq     <= (state_next == ST_REQ);
      irq_vec <= vec_next;
      pend    <= pend_next;
      if (wr_mask) begin
        ge <= o[7];
        en <= o[3:0];
      end
    end
  end

  always_comb begin
    p = 8'h00;
    unique case (a)
      ADDR_MASK: p = {ge, 3'b000, en};
      ADDR_PEND: p = {4'b0000, pend};
      ADDR_STAT: p = {state, 4'b0000, irq_vec};
      default:   p = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the controller kept here.
module tb_irq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] a;
  logic [7:0]  o;
  logic        r, w;
  logic        ev_vblank, ev_kdone, ev_timer, irq_ack;
  logic        irq;
  logic [1:0]  irq_vec;
  logic [7:0]  p;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 requesting, 2 in service.
  int         m_mode;
  logic [7:0] m_mask;
  logic [3:0] m_pend;
  logic [1:0] m_vec;
  logic       m_irq;

  irq_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a         (a),
    .o         (o),
    .r         (r),
    .w         (w),
    .ev_vblank (ev_vblank),
    .ev_kdone  (ev_kdone),
    .ev_timer  (ev_timer),
    .irq_ack   (irq_ack),
    .irq       (irq),
    .irq_vec   (irq_vec),
    .p         (p)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    case (addr)
      16'h0024: return m_mask;
      16'h0025: return {4'b0000, m_pend};
      16'h0026: return {2'(m_mode), 4'b0000, m_vec};
      default:  return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_mask = 8'h00; m_pend = 4'h0; m_vec = 2'd0; m_irq = 1'b0;
  endtask

  // Advance one clock: model sees the inputs present before the edge.
  task automatic step();
    logic [3:0] set_b, clr_b, ack_b, cand;
    int         nm;
    logic [1:0] nv;
    logic [7:0] nmask;
    set_b = {w && a == 16'h0027 && o[0], ev_timer, ev_kdone, ev_vblank};
    clr_b = (w && a == 16'h0025) ? o[3:0] : 4'h0;
    ack_b = 4'h0;
    nm = m_mode; nv = m_vec; nmask = m_mask;
    if (m_mode == 0) begin
      cand = m_pend & m_mask[3:0];
      if (m_mask[7] && cand != 4'h0)
        for (int i = 3; i >= 0; i--) if (cand[i]) begin nm = 1; nv = 2'(i); end
    end else if (m_mode == 1) begin
      if (irq_ack) begin nm = 2; ack_b = 4'(1 << m_vec); end
      else if (!m_mask[7]) nm = 0;
    end else if (w && a == 16'h0026) begin
      nm = 0;
    end
    if (w && a == 16'h0024) nmask = o & 8'h8F;
    @(posedge clock);
    #1;
    m_pend = (m_pend & ~clr_b & ~ack_b) | set_b;
    m_mode = nm; m_vec = nv; m_mask = nmask; m_irq = (nm == 1);
    w = 0; r = 0; irq_ack = 0; ev_vblank = 0; ev_kdone = 0; ev_timer = 0;
    check("irq", 16'(irq), 16'(m_irq));
    check("irq_vec", 16'(irq_vec), 16'(m_vec));
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    a = addr; o = data; w = 1; step();
  endtask

  task automatic rd(input string tag, input logic [15:0] addr);
    a = addr; r = 1; #1;
    check(tag, 16'(p), 16'(model_read(addr)));
    r = 0;
  endtask

  task automatic ack();
    irq_ack = 1; step();
  endtask

  initial begin
    reset_n = 0; a = 16'h0; o = 8'h0; r = 0; w = 0;
    ev_vblank = 0; ev_kdone = 0; ev_timer = 0; irq_ack = 0;
    model_reset();
    #12;
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_vec", 16'(irq_vec), 16'h0);
    rd("rst_mask", 16'h0024);
    rd("rst_stat", 16'h0026);
    reset_n = 1;

    // Vblank request, latency and acknowledge.
    wr(16'h0024, 8'h81);
    ev_vblank = 1; step();
    check("vb_no_irq_yet", 16'(irq), 16'h0);
    step();
    check("vb_irq", 16'(irq), 16'h1);
    check("vb_vec", 16'(irq_vec), 16'h0);
    ack();
    rd("vb_pend", 16'h0025);
    check("vb_pend_c", 16'(p), 16'h00);
    rd("vb_stat", 16'h0026);
    check("vb_stat_c", 16'(p), 16'h80);
    ack();                              // ack outside REQ is ignored
    rd("ack_svc_stat", 16'h0026);
    wr(16'h0026, 8'h00);                // EOI
    rd("eoi_stat", 16'h0026);
    wr(16'h0026, 8'h00);                // EOI outside SERVICE is ignored
    rd("eoi_idle_stat", 16'h0026);

    // Simultaneous timer and keyboard: keyboard wins, timer follows.
    wr(16'h0024, 8'h87);
    ev_timer = 1; ev_kdone = 1; step();
    step();
    check("two_vec1", 16'(irq_vec), 16'h1);
    ack();
    wr(16'h0026, 8'h00);
    step();
    check("two_irq2", 16'(irq), 16'h1);
    check("two_vec2", 16'(irq_vec), 16'h2);

    // Frozen vector while requesting.
    ev_vblank = 1; step();
    step();
    check("frz_vec", 16'(irq_vec), 16'h2);
    ack();
    rd("frz_pend", 16'h0025);
    check("frz_pend_c", 16'(p), 16'h01);
    wr(16'h0026, 8'h00);
    step();
    check("frz_next_vec", 16'(irq_vec), 16'h0);
    ack();
    wr(16'h0026, 8'h00);

    // Event wins over same-cycle W1C; reads have no side effects.
    wr(16'h0024, 8'h00);
    wr(16'h0025, 8'h0F);
    a = 16'h0025; o = 8'h02; w = 1; ev_kdone = 1; step();
    rd("w1c_race", 16'h0025);
    check("w1c_race_c", 16'(p), 16'h02);
    rd("w1c_reread", 16'h0025);
    rd("unmapped", 16'h0124);
    rd("swi_read", 16'h0027);
    wr(16'h0025, 8'h0F);

    // Software interrupt, then GE drop while requesting.
    wr(16'h0024, 8'h88);
    wr(16'h0027, 8'h01);
    step();
    check("swi_vec", 16'(irq_vec), 16'h3);
    wr(16'h0024, 8'h08);
    step();
    check("ge_irq", 16'(irq), 16'h0);
    rd("ge_stat", 16'h0026);
    check("ge_state", 16'(p[7:6]), 16'h0);
    rd("ge_pend", 16'h0025);
    check("ge_pend_c", 16'(p), 16'h08);

    // Asynchronous reset during SERVICE.
    wr(16'h0024, 8'h88);
    step();
    ack();
    rd("svc_stat", 16'h0026);
    reset_n = 0; model_reset(); #1;
    check("arst_irq", 16'(irq), 16'h0);
    rd("arst_stat", 16'h0026);
    check("arst_stat_c", 16'(p), 16'h00);
    rd("arst_mask", 16'h0024);
    check("arst_mask_c", 16'(p), 16'h00);
    #1 reset_n = 1;
    ack();
    rd("idle_ack_stat", 16'h0026);
    check("idle_ack_stat_c", 16'(p), 16'h00);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ev_vblank = ($urandom_range(0, 9) == 0);
      ev_kdone  = ($urandom_range(0, 9) == 0);
      ev_timer  = ($urandom_range(0, 9) == 0);
      irq_ack   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a = 16'h0024 + 16'($urandom_range(0, 3));
        o = 8'($urandom);
        if (a == 16'h0024 && $urandom_range(0, 3) != 0) o[7] = 1'b1;
        w = 1;
      end
      step();
      if (n % 8 == 0) begin
        rd("rnd_mask", 16'h0024);
        rd("rnd_pend", 16'h0025);
        rd("rnd_stat", 16'h0026);
        rd("rnd_other", 16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
